fence_t_sequencer: RTL and testbench
====================================

# fence_t_sequencer

Parametrised temporal-fence (fence.t) sequencer for the CVA6 controller. It flushes the caches, drains any number of handshaked memory ports, pads completion to a selectable timing source, then asserts a counted microarchitectural reset. The block sits beside the flush controller. It owns halt, cache-stall and microreset generation for fence.t, and supports NrDrainPorts drain interfaces and NrPadSrc padding sources.

## Interface
- NrDrainPorts, 2, number of handshaked interfaces that must be idle before reset
- NrPadSrc, 2, number of selectable padding-start event sources
- PadWidth, 32, width of pad value / pad counter / ceiling
- DrainCycles, 16, consecutive idle cycles (all ports) required to leave DRAIN; ≥2
- RstCycles, 16, cycles rst_uarch_no held low; ≥1
- CacheInitCycles, 3, cycles cache_init_no stays high after RST ends
- VLEN, riscv::VLEN, address width
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- boot_addr_i  in  VLEN  reset value of rst_addr_o
- pc_i  in  VLEN  PC of committing fence.t
- fence_t_i  in  1  fence.t committed (single-cycle)
- flush_dcache_o  out  1  dcache flush request
- flush_icache_o  out  1  icache flush pulse
- flush_dcache_ack_i  in  1  dcache flush done
- busy_i  in  NrDrainPorts  per-port transaction outstanding
- pad_sel_i  in  $clog2(NrPadSrc) (min 1)  selects pad event source
- pad_evt_i  in  NrPadSrc  level pad events, rising edge used
- pad_i  in  PadWidth  pad length in cycles
- ceil_o  out  PadWidth  measured ceiling
- ceil_valid_o  out  1  ceil_o qualifier
- halt_o  out  1  halt commit
- stall_o  out  1  cache must accept no new requests
- rst_uarch_no  out  1  microreset, active-low
- cache_init_no  out  1  suppress cache init
- rst_addr_o  out  VLEN  PC to resume at after microreset

## Operation
- States: IDLE, FLUSH, DRAIN, PAD, RST. Transitions:
  - IDLE→FLUSH on fence_t_i.
  - FLUSH→DRAIN on flush_dcache_ack_i.
  - DRAIN→PAD when drain_cnt==DrainCycles-1 and busy_i=='0.
  - PAD→RST when pad_cnt==0.
  - RST→IDLE when rst_cnt==RstCycles-1.
  - Illegal encoding→IDLE.
- fence_t_i outside IDLE is ignored; no queueing.
- On accepted fence_t_i: rst_addr_o ← pc_i+4 (wraps modulo 2^VLEN).
- flush_dcache_o: high in every FLUSH cycle. flush_icache_o: high only in the first FLUSH cycle.
- drain_cnt: clears to 0 when state≠DRAIN or when any busy_i bit is set. Otherwise it increments and saturates at DrainCycles-1.
- pad_cnt: runs in every state.
  - Loads pad_i on the rising edge of pad_evt_i[pad_sel_i]. The edge is detected against a registered copy of all pad_evt_i.
  - Otherwise decrements while nonzero.
  - Load beats decrement. pad_sel_i ≥ NrPadSrc selects no source.
- On the DRAIN→PAD cycle: ceil_valid_o=1 and ceil_o = (pad_cnt==0) ? 0 : pad_i−pad_cnt. At all other times ceil_valid_o=0 and ceil_o=0.
- RST: rst_uarch_no=0 and rst_cnt counts up. rst_cnt returns to 0 on exit.
- cache_init_no: high during RST and for CacheInitCycles cycles after it, via a shift register fed by (state==RST).
- halt_o = (state≠IDLE). stall_o = state ∈ {DRAIN, PAD, RST}.

## Timing
- Reset values:
  - state=IDLE; all counters 0.
  - flush_dcache_o, flush_icache_o, ceil_valid_o, halt_o, stall_o, cache_init_no = 0; ceil_o = 0.
  - rst_uarch_no=1; rst_addr_o=boot_addr_i.
- Outputs except ceil_o/ceil_valid_o are decoded from registered state only. ceil_o/ceil_valid_o are combinational on pad_cnt/pad_i within that cycle.
- fence_t_i at cycle t: FLUSH, halt_o and flush outputs in t+1.
- Minimum DRAIN dwell is DrainCycles cycles. A busy_i bit set in the exit cycle blocks exit and restarts the count.
- Ack in the first FLUSH cycle is valid: DRAIN starts next cycle.
- pad_cnt==0 on DRAIN exit (no event or already expired): PAD lasts exactly 1 cycle.
- A pad event edge during PAD reloads the counter and extends PAD.
- rst_uarch_no low for exactly RstCycles cycles. cache_init_no falls CacheInitCycles cycles after rst_uarch_no rises.
- Async reset mid-sequence: immediate return to reset values; the sequence is not resumed.

## Structure
- fence_t_state_e (logic[2:0]) goes in ariane_pkg for reuse by the controller and perf counters.
- Sub-module: common_cells counter, two instances.
  - i_drain_cnt: width $clog2(DrainCycles).
  - i_pad_cnt: width PadWidth, down, load.
- rst_cnt and the init shift register are inline.

## Test plan
- Default params: fence_t_i with pc_i=0x8000_0FFC, ack 3 cycles later, busy_i=0. Expect FLUSH 3 cycles, DRAIN 16, PAD 1, RST 16 (rst_uarch_no low), cache_init_no high for 19 cycles, rst_addr_o=0x8000_1000.
- busy_i[1] pulses at DRAIN cycles 10 and 30. Expect exit only 16 idle cycles after cycle 30; stall_o high throughout.
- pad_sel_i=1, pad_i=100, edge on pad_evt_i[1] 40 cycles before DRAIN exit. Expect ceil_valid_o pulse with ceil_o=40, then PAD 60 cycles.
- Edge on unselected pad_evt_i[0]. Expect pad_cnt unaffected, ceil_o=0, PAD 1 cycle.
- Second fence_t_i during PAD ignored; rst_addr_o unchanged. rst_ni asserted mid-RST: rst_uarch_no=1, halt_o=0, rst_addr_o=boot_addr_i immediately.

Source files
------------

// File: rtl/fence_t_sequencer_pkg.sv
// Shared types and helpers for the fence.t sequencer and its neighbours
// (flush controller, performance counters).
package fence_t_sequencer_pkg;

    typedef enum logic [2:0] {
        FT_IDLE  = 3'd0,
        FT_FLUSH = 3'd1,
        FT_DRAIN = 3'd2,
        FT_PAD   = 3'd3,
        FT_RST   = 3'd4
    } fence_t_state_e;

    // Stand-in for riscv::VLEN when the core package is not in scope.
    localparam int unsigned DefaultVlen = 64;

    // Counter/select width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fence_t_sequencer_counter.sv
// Generic up/down counter with synchronous clear and parallel load.
// Priority: clear, then load, then count.
module fence_t_sequencer_counter #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic             down_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] cnt_q;

    // Counter register: clear beats load, load beats count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= d_i;
        end else if (en_i) begin
            cnt_q <= down_i ? (cnt_q - Width'(1)) : (cnt_q + Width'(1));
        end
    end

    assign q_o = cnt_q;

endmodule

// File: rtl/fence_t_sequencer.sv
// Temporal-fence (fence.t) sequencer: flushes caches, waits for all memory
// ports to go quiet, pads completion to a selectable timing source, then
// pulses a counted microarchitectural reset and resumes at pc+4.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// FT_IDLE  | waiting for a committed fence.t
// FT_FLUSH | dcache flush requested (icache pulsed on first cycle)
// FT_DRAIN | waiting for DrainCycles consecutive idle cycles on all ports
// FT_PAD   | waiting for the pad counter to expire
// FT_RST   | microreset asserted for RstCycles cycles
module fence_t_sequencer
    import fence_t_sequencer_pkg::*;
#(
    parameter int unsigned NrDrainPorts    = 2,
    parameter int unsigned NrPadSrc        = 2,
    parameter int unsigned PadWidth        = 32,
    parameter int unsigned DrainCycles     = 16,
    parameter int unsigned RstCycles       = 16,
    parameter int unsigned CacheInitCycles = 3,
    parameter int unsigned VLEN            = DefaultVlen
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [VLEN-1:0]                   boot_addr_i,
    input  logic [VLEN-1:0]                   pc_i,
    input  logic                              fence_t_i,
    output logic                              flush_dcache_o,
    output logic                              flush_icache_o,
    input  logic                              flush_dcache_ack_i,
    input  logic [NrDrainPorts-1:0]           busy_i,
    input  logic [clog2_min1(NrPadSrc)-1:0]   pad_sel_i,
    input  logic [NrPadSrc-1:0]               pad_evt_i,
    input  logic [PadWidth-1:0]               pad_i,
    output logic [PadWidth-1:0]               ceil_o,
    output logic                              ceil_valid_o,
    output logic                              halt_o,
    output logic                              stall_o,
    output logic                              rst_uarch_no,
    output logic                              cache_init_no,
    output logic [VLEN-1:0]                   rst_addr_o
);

    localparam int unsigned DrainW  = clog2_min1(DrainCycles);
    localparam int unsigned RstW    = clog2_min1(RstCycles);
    localparam int unsigned PadSelW = clog2_min1(NrPadSrc);
    // A zero-length init tail still needs a one-bit register; it is masked below.
    localparam int unsigned InitW   = (CacheInitCycles > 0) ? CacheInitCycles : 1;

    localparam logic [DrainW-1:0] DrainLast = DrainW'(DrainCycles - 1);
    localparam logic [RstW-1:0]   RstLast   = RstW'(RstCycles - 1);

    fence_t_state_e      state_q;
    logic [RstW-1:0]     rst_cnt_q;
    logic [VLEN-1:0]     rst_addr_q;
    logic                flush_seen_q;
    logic [InitW-1:0]    init_sr_q;
    logic [NrPadSrc-1:0] pad_evt_q;

    logic [DrainW-1:0]   drain_cnt;
    logic [PadWidth-1:0] pad_cnt;
    logic [NrPadSrc-1:0] pad_rise;
    logic                pad_load;
    logic                pad_zero;
    logic                ports_idle;
    logic                drain_exit;
    logic                in_rst;

    assign ports_idle = ~|busy_i;
    assign pad_zero   = (pad_cnt == '0);
    assign drain_exit = (state_q == FT_DRAIN) && ports_idle && (drain_cnt == DrainLast);
    assign pad_rise   = pad_evt_i & ~pad_evt_q;
    assign in_rst     = (state_q == FT_RST);

    // Select the rising edge of the chosen pad source; out-of-range selects nothing.
    always_comb begin
        pad_load = 1'b0;
        for (int unsigned i = 0; i < NrPadSrc; i++) begin
            if (pad_sel_i == PadSelW'(i)) begin
                pad_load = pad_rise[i];
            end
        end
    end

    // Previous-cycle copy of all pad events for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pad_evt_q <= '0;
        end else begin
            pad_evt_q <= pad_evt_i;
        end
    end

    // Consecutive idle cycles in DRAIN; any busy port restarts the count.
    fence_t_sequencer_counter #(
        .Width (DrainW)
    ) i_drain_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i ((state_q != FT_DRAIN) || !ports_idle),
        .en_i    (drain_cnt != DrainLast),
        .load_i  (1'b0),
        .down_i  (1'b0),
        .d_i     ('0),
        .q_o     (drain_cnt)
    );

    // Free-running pad timer: loads on the selected edge, otherwise counts down to zero.
    fence_t_sequencer_counter #(
        .Width (PadWidth)
    ) i_pad_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (1'b0),
        .en_i    (!pad_zero),
        .load_i  (pad_load),
        .down_i  (1'b1),
        .d_i     (pad_i),
        .q_o     (pad_cnt)
    );

    // Sequencer FSM with reset-length counter, resume address and init tail.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= FT_IDLE;
            rst_cnt_q    <= '0;
            rst_addr_q   <= boot_addr_i;
            flush_seen_q <= 1'b0;
            init_sr_q    <= '0;
        end else begin
            flush_seen_q <= (state_q == FT_FLUSH);
            init_sr_q    <= (init_sr_q << 1) | InitW'(in_rst);
            case (state_q)
                FT_IDLE: begin
                    if (fence_t_i) begin
                        state_q    <= FT_FLUSH;
                        rst_addr_q <= pc_i + VLEN'(4);
                    end
                end
                FT_FLUSH: begin
                    if (flush_dcache_ack_i) begin
                        state_q <= FT_DRAIN;
                    end
                end
                FT_DRAIN: begin
                    if (drain_exit) begin
                        state_q <= FT_PAD;
                    end
                end
                FT_PAD: begin
                    if (pad_zero) begin
                        state_q <= FT_RST;
                    end
                end
                FT_RST: begin
                    if (rst_cnt_q == RstLast) begin
                        state_q   <= FT_IDLE;
                        rst_cnt_q <= '0;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + RstW'(1);
                    end
                end
                default: begin
                    state_q   <= FT_IDLE;
                    rst_cnt_q <= '0;
                end
            endcase
        end
    end

    assign flush_dcache_o = (state_q == FT_FLUSH);
    assign flush_icache_o = (state_q == FT_FLUSH) && !flush_seen_q;
    assign halt_o         = (state_q != FT_IDLE);
    assign stall_o        = (state_q == FT_DRAIN) || (state_q == FT_PAD) || in_rst;
    assign rst_uarch_no   = !in_rst;
    assign cache_init_no  = in_rst || ((CacheInitCycles > 0) && (|init_sr_q));
    assign rst_addr_o     = rst_addr_q;

    // Measured ceiling is only meaningful on the cycle DRAIN hands over to PAD.
    assign ceil_valid_o = drain_exit;
    assign ceil_o       = (drain_exit && !pad_zero) ? (pad_i - pad_cnt) : '0;

endmodule

// File: tb/tb_fence_t_sequencer.sv
// Self-checking bench for fence_t_sequencer: a timestamp-based model of the
// sequencing rules is compared against the DUT every cycle, plus literal
// phase-length and address expectations per scenario.
module tb_fence_t_sequencer;

    localparam int NR_DRAIN  = 2;
    localparam int NR_PAD    = 2;
    localparam int PADW      = 32;
    localparam int DRAIN_CYC = 16;
    localparam int RST_CYC   = 16;
    localparam int INIT_CYC  = 3;
    localparam int VL        = 64;
    localparam logic [VL-1:0] BOOT = 64'h0000_0000_8000_0000;

    localparam int P_IDLE  = 0;
    localparam int P_FLUSH = 1;
    localparam int P_DRAIN = 2;
    localparam int P_PAD   = 3;
    localparam int P_RST   = 4;

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic [VL-1:0]       boot_addr_i;
    logic [VL-1:0]       pc_i;
    logic                fence_t_i;
    logic                flush_dcache_o;
    logic                flush_icache_o;
    logic                flush_dcache_ack_i;
    logic [NR_DRAIN-1:0] busy_i;
    logic [0:0]          pad_sel_i;
    logic [NR_PAD-1:0]   pad_evt_i;
    logic [PADW-1:0]     pad_i;
    logic [PADW-1:0]     ceil_o;
    logic                ceil_valid_o;
    logic                halt_o;
    logic                stall_o;
    logic                rst_uarch_no;
    logic                cache_init_no;
    logic [VL-1:0]       rst_addr_o;

    always #5 clk_i = ~clk_i;

    fence_t_sequencer #(
        .NrDrainPorts    (NR_DRAIN),
        .NrPadSrc        (NR_PAD),
        .PadWidth        (PADW),
        .DrainCycles     (DRAIN_CYC),
        .RstCycles       (RST_CYC),
        .CacheInitCycles (INIT_CYC),
        .VLEN            (VL)
    ) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .boot_addr_i        (boot_addr_i),
        .pc_i               (pc_i),
        .fence_t_i          (fence_t_i),
        .flush_dcache_o     (flush_dcache_o),
        .flush_icache_o     (flush_icache_o),
        .flush_dcache_ack_i (flush_dcache_ack_i),
        .busy_i             (busy_i),
        .pad_sel_i          (pad_sel_i),
        .pad_evt_i          (pad_evt_i),
        .pad_i              (pad_i),
        .ceil_o             (ceil_o),
        .ceil_valid_o       (ceil_valid_o),
        .halt_o             (halt_o),
        .stall_o            (stall_o),
        .rst_uarch_no       (rst_uarch_no),
        .cache_init_no      (cache_init_no),
        .rst_addr_o         (rst_addr_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // model state: phase plus timestamps rather than counters
    int            m_phase;
    longint        cyc = 0;
    longint        m_start;
    int            m_idle_run;
    bit            m_loaded;
    longint        m_load_cyc;
    longint        m_load_val;
    logic [NR_PAD-1:0] m_prev_evt;
    logic [VL-1:0] m_addr;
    bit            m_seen_rst;
    longint        m_last_rst;

    // observed phase lengths per scenario
    int obs_fd, obs_fi, obs_stall, obs_rstlow, obs_init, obs_ceilv;
    logic [PADW-1:0] last_ceil;

    task automatic chk(input string name, input logic [VL-1:0] act, input logic [VL-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic longint pad_now();
        longint v;
        if (!m_loaded) return 0;
        v = m_load_val - (cyc - m_load_cyc - 1);
        return (v < 0) ? 0 : v;
    endfunction

    function automatic bit drain_exit_now();
        return (m_phase == P_DRAIN) && (busy_i == '0) && (m_idle_run + 1 >= DRAIN_CYC);
    endfunction

    task automatic model_reset();
        m_phase    = P_IDLE;
        m_start    = 0;
        m_idle_run = 0;
        m_loaded   = 0;
        m_load_cyc = 0;
        m_load_val = 0;
        m_prev_evt = '0;
        m_addr     = BOOT;
        m_seen_rst = 0;
        m_last_rst = 0;
    endtask

    task automatic clear_obs();
        obs_fd = 0; obs_fi = 0; obs_stall = 0; obs_rstlow = 0; obs_init = 0; obs_ceilv = 0;
        last_ceil = '0;
    endtask

    task automatic check_cycle();
        longint p;
        bit ex;
        logic [PADW-1:0] e_ceil;
        p  = pad_now();
        ex = drain_exit_now();
        e_ceil = (ex && p != 0) ? (pad_i - p[PADW-1:0]) : '0;
        chk("halt", halt_o, m_phase != P_IDLE);
        chk("stall", stall_o, m_phase >= P_DRAIN);
        chk("flush_dcache", flush_dcache_o, m_phase == P_FLUSH);
        chk("flush_icache", flush_icache_o, (m_phase == P_FLUSH) && (cyc == m_start));
        chk("rst_uarch_n", rst_uarch_no, m_phase != P_RST);
        chk("cache_init_n", cache_init_no,
            (m_phase == P_RST) || (m_seen_rst && (cyc - m_last_rst <= INIT_CYC)));
        chk("ceil_valid", ceil_valid_o, ex);
        chk("ceil", ceil_o, e_ceil);
        chk("rst_addr", rst_addr_o, m_addr);
        obs_fd     += int'(flush_dcache_o);
        obs_fi     += int'(flush_icache_o);
        obs_stall  += int'(stall_o);
        obs_rstlow += int'(!rst_uarch_no);
        obs_init   += int'(cache_init_no);
        if (ceil_valid_o) begin
            obs_ceilv++;
            last_ceil = ceil_o;
        end
    endtask

    task automatic model_step();
        longint p;
        int sel;
        p   = pad_now();
        sel = int'(pad_sel_i);
        if (sel < NR_PAD && pad_evt_i[sel] && !m_prev_evt[sel]) begin
            m_loaded   = 1;
            m_load_cyc = cyc;
            m_load_val = longint'(pad_i);
        end
        m_prev_evt = pad_evt_i;
        case (m_phase)
            P_IDLE: if (fence_t_i) begin
                m_phase = P_FLUSH;
                m_start = cyc + 1;
                m_addr  = pc_i + 64'd4;
            end
            P_FLUSH: if (flush_dcache_ack_i) begin
                m_phase    = P_DRAIN;
                m_idle_run = 0;
            end
            P_DRAIN: begin
                if (busy_i != '0) m_idle_run = 0;
                else if (m_idle_run + 1 >= DRAIN_CYC) m_phase = P_PAD;
                else m_idle_run++;
            end
            P_PAD: if (p == 0) begin
                m_phase = P_RST;
                m_start = cyc + 1;
            end
            default: begin
                m_seen_rst = 1;
                m_last_rst = cyc;
                if (cyc - m_start + 1 == RST_CYC) m_phase = P_IDLE;
            end
        endcase
        cyc++;
    endtask

    // inputs for the current cycle are already applied at the preceding negedge
    task automatic tick();
        #1;
        check_cycle();
        model_step();
        @(negedge clk_i);
    endtask

    task automatic start_fence(input logic [VL-1:0] pc);
        pc_i = pc;
        fence_t_i = 1'b1;
        tick();
        fence_t_i = 1'b0;
        tick();
        tick();
        flush_dcache_ack_i = 1'b1;
        tick();
        flush_dcache_ack_i = 1'b0;
    endtask

    // full sequence; busy pulses and an unselected pad event at DRAIN-relative cycles
    task automatic fence_seq(input logic [VL-1:0] pc, input int busy_a, input int busy_b, input int evt0_k);
        bit done;
        done = 0;
        clear_obs();
        start_fence(pc);
        for (int k = 1; k <= 400; k++) begin
            busy_i       = (k == busy_a || k == busy_b) ? 2'b10 : 2'b00;
            pad_evt_i[0] = (k == evt0_k);
            tick();
            if (!halt_o && !cache_init_no) begin
                done = 1;
                break;
            end
        end
        busy_i = '0;
        pad_evt_i[0] = 1'b0;
        chk("sequence_completes", done, 1'b1);
    endtask

    initial begin
        bit done;
        int rst_low;
        rst_ni = 1'b0;
        boot_addr_i = BOOT;
        pc_i = '0;
        fence_t_i = 1'b0;
        flush_dcache_ack_i = 1'b0;
        busy_i = '0;
        pad_sel_i = 1'b0;
        pad_evt_i = '0;
        pad_i = '0;
        model_reset();
        clear_obs();
        @(negedge clk_i);
        @(negedge clk_i);

        // reset values
        chk("rst_halt", halt_o, 1'b0);
        chk("rst_stall", stall_o, 1'b0);
        chk("rst_flush_d", flush_dcache_o, 1'b0);
        chk("rst_flush_i", flush_icache_o, 1'b0);
        chk("rst_uarch", rst_uarch_no, 1'b1);
        chk("rst_cache_init", cache_init_no, 1'b0);
        chk("rst_ceil_valid", ceil_valid_o, 1'b0);
        chk("rst_ceil", ceil_o, '0);
        chk("rst_addr_boot", rst_addr_o, BOOT);
        rst_ni = 1'b1;
        repeat (3) tick();

        // 1: basic sequence, ack in third FLUSH cycle, quiet ports, no pad
        fence_seq(64'h0000_0000_8000_0FFC, 0, 0, 0);
        chk("t1_flush_cycles", obs_fd, 3);
        chk("t1_icache_pulses", obs_fi, 1);
        chk("t1_stall_cycles", obs_stall, 16 + 1 + 16);
        chk("t1_rst_low_cycles", obs_rstlow, 16);
        chk("t1_cache_init_cycles", obs_init, 19);
        chk("t1_ceil_pulses", obs_ceilv, 1);
        chk("t1_ceil", last_ceil, 0);
        chk("t1_rst_addr", rst_addr_o, 64'h0000_0000_8000_1000);

        // 2: busy at DRAIN cycle 10 and again in the would-be exit cycle 26
        fence_seq(64'h0000_0000_0000_2000, 10, 26, 0);
        chk("t2_stall_cycles", obs_stall, 42 + 1 + 16);
        chk("t2_rst_low_cycles", obs_rstlow, 16);
        chk("t2_rst_addr", rst_addr_o, 64'h0000_0000_0000_2004);

        // 3: selected pad edge 41 cycles before DRAIN exit, pad 100
        pad_sel_i = 1'b1;
        pad_i = 32'd100;
        pad_evt_i = 2'b10;
        tick();
        repeat (21) tick();
        fence_seq(64'h0000_0000_0000_3000, 0, 0, 0);
        chk("t3_ceil_pulses", obs_ceilv, 1);
        chk("t3_ceil", last_ceil, 40);
        chk("t3_stall_cycles", obs_stall, 16 + 60 + 16);

        // 4: edge only on the unselected source
        fence_seq(64'h0000_0000_0000_4000, 0, 0, 5);
        chk("t4_ceil", last_ceil, 0);
        chk("t4_ceil_pulses", obs_ceilv, 1);
        chk("t4_stall_cycles", obs_stall, 16 + 1 + 16);

        // 5: pad during DRAIN, ignored fence and reload during PAD, async reset mid-RST
        pad_evt_i = 2'b00;
        pad_i = 32'd30;
        tick();
        clear_obs();
        start_fence(64'hFFFF_FFFF_FFFF_FFFE);
        done = 0;
        rst_low = 0;
        for (int k = 1; k <= 300; k++) begin
            pad_evt_i[1] = (k >= 8 && k < 25) || (k >= 26);
            pad_i        = (k >= 26) ? 32'd40 : 32'd30;
            fence_t_i    = (k == 21);
            if (k == 21) pc_i = 64'h0000_0000_0000_1234;
            tick();
            if (k == 30) chk("t5_addr_after_ignored_fence", rst_addr_o, 64'h2);
            if (!rst_uarch_no) rst_low++;
            if (rst_low == 5) begin
                done = 1;
                break;
            end
        end
        fence_t_i = 1'b0;
        chk("t5_reached_rst", done, 1'b1);
        chk("t5_ceil", last_ceil, 7);
        chk("t5_drain_plus_pad", obs_stall - obs_rstlow, 16 + 51);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t5_async_rst_uarch", rst_uarch_no, 1'b1);
        chk("t5_async_halt", halt_o, 1'b0);
        chk("t5_async_stall", stall_o, 1'b0);
        chk("t5_async_cache_init", cache_init_no, 1'b0);
        chk("t5_async_addr", rst_addr_o, BOOT);
        @(negedge clk_i);
        @(negedge clk_i);
        pad_evt_i = '0;
        busy_i = '0;
        rst_ni = 1'b1;
        model_reset();
        repeat (5) tick();
        chk("t5_not_resumed", halt_o, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
